dcmac_rx_pktbuf: RTL and testbench
==================================

# dcmac_rx_pktbuf

Parametrised DCMAC receive segment buffer that registers N input segments, masks unused bytes, and writes each enabled segment into its own AXI-stream FIFO (segment i always goes to FIFO i). Unlike the prior fixed 4x128 buffer, it never overflows silently:
- **Admission:** a packet is admitted only when every FIFO has enough headroom at its start-of-packet.
- **Truncation:** an admitted packet that runs a FIFO out of space is terminated early with an error flag.
- **Statistics:** drops, truncations and framing errors are counted.

It sits between the DCMAC RX client interface and the downstream segment reassembler.

## Interface
Parameters:
- NUM_SEG, 4, number of segments (1–4).
- SEG_W, 128, segment data width in bits; multiple of 8.
- MTY_W, $clog2(SEG_W/8), width of the empty-byte count.
- FIFO_DEPTH, 512, depth of each xpm_fifo_axis (power of 2).
- ADMIT_FREE, 64, minimum free slots required in every FIFO to admit a packet; must be ≥2.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  input beat valid.
- i_data  in  NUM_SEG*SEG_W  segment i at [i*SEG_W +: SEG_W].
- i_ena, i_sop, i_eop, i_err  in  NUM_SEG each  per-segment flags; bit i belongs to segment i.
- i_mty  in  NUM_SEG*MTY_W  per-segment empty-byte count.
- seg_tdata  out  NUM_SEG*SEG_W  FIFO outputs.
- seg_tid  out  NUM_SEG*MTY_W  carries mty.
- seg_tuser  out  NUM_SEG*3  {ena, sop, err}.
- seg_tlast, seg_tvalid  out  NUM_SEG  per-FIFO last and valid.
- seg_tready  in  NUM_SEG  per-FIFO ready.
- drop_count, trunc_count, proto_err_count  out  32 each  saturating statistics counters.

## Operation
**Input register**
- All inputs are registered once.
- A segment is active when registered valid & ena[i]. Inactive segments are skipped and leave all state unchanged.

**Data formatting**
- tdata = data & mask, where mask keeps the low SEG_W-8*mty bits and zeroes the rest.
- tid = mty.
- tuser = {1, sop, err}.
- tlast = eop, except on truncation.

**Occupancy tracking**
- occ[i] is a counter of width $clog2(FIFO_DEPTH)+1.
- It increments on a write to FIFO i and decrements on seg_tvalid[i] & seg_tready[i]; both in one cycle leave it unchanged.
- Usable capacity is C = FIFO_DEPTH-1.
- All decisions use occ at the start of the cycle.

**Packet state machine**
- State is global: IDLE, PASS, DROP.
- Active segments are walked in order 0..NUM_SEG-1 within a cycle; the state chains combinationally from segment to segment.
- sop segment (any state):
  - If the state was PASS or DROP, no eop was seen: proto_err_count += 1.
  - Admit when C-occ[j] ≥ ADMIT_FREE for all j. Admitted: the segment is processed as PASS. Not admitted: drop_count += 1 and state = DROP.
- PASS segment, not eop:
  - occ[i] ≤ C-2: write it.
  - occ[i] = C-1: write it with tlast=1 and err=1, trunc_count += 1, state = DROP.
- PASS segment, eop: write it (occ[i] ≤ C-1 is guaranteed), then state = IDLE.
- DROP segment: not written. An eop returns the state to IDLE.
- IDLE segment without sop: not written, proto_err_count += 1.

**Counters**
- Several events can occur in one cycle; each counter adds the number of its events that cycle.
- Counters saturate at 2^32-1.

**Constraints**
- FIFO s_axis_tready is ignored.
- The design guarantees no write ever occurs with occ = C.

## Timing
- Inputs are sampled at edge N; the corresponding FIFO writes happen at edge N+1.
- The state and occ updates of that cycle are also committed at edge N+1.
- Output latency is the xpm_fifo_axis standard-mode latency (constant). Per-FIFO ordering is preserved.
- A packet spanning cycles keeps its state across idle cycles (i_valid=0 or all ena=0).
- Reset, any time:
  - State = IDLE, occ = 0, counters = 0, input register cleared.
  - FIFOs are flushed; seg_tvalid = 0 from the cycle after reset is sampled until new data is written.
  - Beats sampled while reset is high are discarded.
  - A packet in flight at reset is lost. The next non-sop segment counts as a protocol error.

## Test plan
- **Single packet, NUM_SEG=4:** sop on seg0, eop on seg2 with mty=5, seg3 ena=0 -> FIFOs 0–2 each receive one entry. FIFO2 has tlast=1, tid=5 and the top 40 bits zeroed. FIFO3 stays empty. All counters stay 0.
- **Admission drop:** seg_tready=0 and FIFO1 filled to occ=C-63 (free=63), then a 3-segment packet -> nothing is written, drop_count=1, and the next packet after draining is written normally.
- **Truncation:** ADMIT_FREE=2, FIFO_DEPTH=16, tready=0, a long packet streamed on seg0 only -> the write at occ=C-1 carries tlast=1 and err=1, trunc_count=1, the rest is discarded until eop, and the next sop is rejected (drop_count=1).
- **Framing error:** sop, sop, eop across three cycles -> proto_err_count=1 and both sops are admitted.
- **Reset mid-packet** after sop plus 2 segments, then the eop segment -> all FIFOs are empty, and the eop in IDLE gives proto_err_count=1.
- **Saturation:** force drop_count to 2^32-2, then three drops in one cycle -> drop_count=2^32-1.

Source files
------------

// File: rtl/dcmac_rx_pktbuf.sv
// dcmac_rx_pktbuf: DCMAC RX segment buffer. Registers NUM_SEG input segments, masks the
// unused bytes and writes segment i into FIFO i. Packets are admitted only when every FIFO
// has headroom. An admitted packet that exhausts a FIFO is cut short with an error flag.
module dcmac_rx_pktbuf #(
    parameter int NUM_SEG    = 4,
    parameter int SEG_W      = 128,
    parameter int MTY_W      = $clog2(SEG_W / 8),
    parameter int FIFO_DEPTH = 512,
    parameter int ADMIT_FREE = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [NUM_SEG*SEG_W-1:0] i_data,
    input  logic [NUM_SEG-1:0]       i_ena,
    input  logic [NUM_SEG-1:0]       i_sop,
    input  logic [NUM_SEG-1:0]       i_eop,
    input  logic [NUM_SEG-1:0]       i_err,
    input  logic [NUM_SEG*MTY_W-1:0] i_mty,
    output logic [NUM_SEG*SEG_W-1:0] seg_tdata,
    output logic [NUM_SEG*MTY_W-1:0] seg_tid,
    output logic [NUM_SEG*3-1:0]     seg_tuser,
    output logic [NUM_SEG-1:0]       seg_tlast,
    output logic [NUM_SEG-1:0]       seg_tvalid,
    input  logic [NUM_SEG-1:0]       seg_tready,
    output logic [31:0]              drop_count,
    output logic [31:0]              trunc_count,
    output logic [31:0]              proto_err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(NUM_SEG + 1);
    localparam int EW = 1 + MTY_W + 3 + SEG_W;
    // Usable capacity is one less than the memory depth.
    localparam logic [OW-1:0] CAP    = OW'(FIFO_DEPTH - 1);
    localparam logic [OW-1:0] CAP_M1 = OW'(FIFO_DEPTH - 2);
    localparam logic [OW-1:0] ADMIT  = OW'(ADMIT_FREE);

    typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [CW-1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + 33'(inc);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic                     valid_q;
    logic [NUM_SEG*SEG_W-1:0] data_q;
    logic [NUM_SEG-1:0]       ena_q, sop_q, eop_q, err_q;
    logic [NUM_SEG*MTY_W-1:0] mty_q;

    state_e                   state_q, state_d;
    logic [NUM_SEG*OW-1:0]    occ;
    logic [NUM_SEG-1:0]       wr_en, wr_trunc;
    logic [CW-1:0]            n_drop, n_trunc, n_proto;
    logic                     admit;
    logic [31:0]              drop_cnt_q, trunc_cnt_q, proto_cnt_q;

    assign drop_count      = drop_cnt_q;
    assign trunc_count     = trunc_cnt_q;
    assign proto_err_count = proto_cnt_q;

    // Input register; cleared on reset so beats sampled during reset are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ena_q   <= '0;
            sop_q   <= '0;
            eop_q   <= '0;
            err_q   <= '0;
            mty_q   <= '0;
        end else begin
            valid_q <= i_valid;
            data_q  <= i_data;
            ena_q   <= i_ena;
            sop_q   <= i_sop;
            eop_q   <= i_eop;
            err_q   <= i_err;
            mty_q   <= i_mty;
        end
    end

    // Admission: every FIFO must have ADMIT_FREE free slots at start of cycle.
    always_comb begin
        admit = 1'b1;
        for (int j = 0; j < NUM_SEG; j++) begin
            if (CAP - occ[j*OW +: OW] < ADMIT) admit = 1'b0;
        end
    end

    // Walk active segments in order; packet state chains from one segment to the next.
    always_comb begin
        state_d  = state_q;
        wr_en    = '0;
        wr_trunc = '0;
        n_drop   = '0;
        n_trunc  = '0;
        n_proto  = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (valid_q && ena_q[i]) begin
                if (sop_q[i]) begin
                    // A new sop while a packet is open means the previous eop went missing.
                    if (state_d != StIdle) n_proto = n_proto + CW'(1);
                    if (admit) begin
                        state_d = StPass;
                    end else begin
                        state_d = StDrop;
                        n_drop  = n_drop + CW'(1);
                    end
                end else if (state_d == StIdle) begin
                    n_proto = n_proto + CW'(1);
                end
                case (state_d)
                    StPass: begin
                        wr_en[i] = 1'b1;
                        if (eop_q[i]) begin
                            state_d = StIdle;
                        end else if (occ[i*OW +: OW] >= CAP_M1) begin
                            // Last free slot: close the packet here with an error.
                            wr_trunc[i] = 1'b1;
                            n_trunc     = n_trunc + CW'(1);
                            state_d     = StDrop;
                        end
                    end
                    StDrop: begin
                        if (eop_q[i]) state_d = StIdle;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Packet state and saturating statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
            proto_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drop_cnt_q  <= sat_add(drop_cnt_q, n_drop);
            trunc_cnt_q <= sat_add(trunc_cnt_q, n_trunc);
            proto_cnt_q <= sat_add(proto_cnt_q, n_proto);
        end
    end

    for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
        logic [SEG_W-1:0] mask;
        logic [EW-1:0]    wr_entry;
        logic [EW-1:0]    rd_entry;
        logic [EW-1:0]    mem [FIFO_DEPTH];
        logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
        logic [OW-1:0]    occ_q;
        logic             pop;

        assign mask     = {SEG_W{1'b1}} >> {mty_q[s*MTY_W +: MTY_W], 3'b000};
        assign wr_entry = {eop_q[s] | wr_trunc[s], mty_q[s*MTY_W +: MTY_W],
                           1'b1, sop_q[s], err_q[s] | wr_trunc[s],
                           data_q[s*SEG_W +: SEG_W] & mask};

        assign occ[s*OW +: OW] = occ_q;
        assign seg_tvalid[s]   = (occ_q != '0);
        assign pop             = seg_tvalid[s] & seg_tready[s];
        assign rd_entry        = mem[rd_ptr_q];
        assign {seg_tlast[s], seg_tid[s*MTY_W +: MTY_W], seg_tuser[s*3 +: 3],
                seg_tdata[s*SEG_W +: SEG_W]} = rd_entry;

        // FIFO storage; contents need no reset since occupancy gates validity.
        always_ff @(posedge clk) begin
            if (wr_en[s] && !reset) mem[wr_ptr_q] <= wr_entry;
        end

        // Pointers and occupancy; simultaneous write and pop leave occupancy unchanged.
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (wr_en[s]) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
                case ({wr_en[s], pop})
                    2'b10:   occ_q <= occ_q + OW'(1);
                    2'b01:   occ_q <= occ_q - OW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dcmac_rx_pktbuf.sv
// Self-checking bench for dcmac_rx_pktbuf: directed packets, per-FIFO scoreboard queues.
module tb_dcmac_rx_pktbuf;
    localparam int NS    = 4;
    localparam int SW    = 64;
    localparam int MW    = 3;
    localparam int DEPTH = 16;
    localparam int AF    = 4;

    typedef struct packed {
        logic [SW-1:0] data;
        logic [MW-1:0] tid;
        logic [2:0]    user;
        logic          last;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_valid = 1'b0;
    logic [NS*SW-1:0]  i_data = '0;
    logic [NS-1:0]     i_ena = '0, i_sop = '0, i_eop = '0, i_err = '0;
    logic [NS*MW-1:0]  i_mty = '0;
    logic [NS*SW-1:0]  seg_tdata;
    logic [NS*MW-1:0]  seg_tid;
    logic [NS*3-1:0]   seg_tuser;
    logic [NS-1:0]     seg_tlast, seg_tvalid;
    logic [NS-1:0]     seg_tready = '1;
    logic [31:0]       drop_count, trunc_count, proto_err_count;

    int   checks = 0;
    int   errors = 0;
    ent_t exp_q [NS][$];

    always #5 clk = ~clk;

    dcmac_rx_pktbuf #(
        .NUM_SEG   (NS),
        .SEG_W     (SW),
        .MTY_W     (MW),
        .FIFO_DEPTH(DEPTH),
        .ADMIT_FREE(AF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_ena          (i_ena),
        .i_sop          (i_sop),
        .i_eop          (i_eop),
        .i_err          (i_err),
        .i_mty          (i_mty),
        .seg_tdata      (seg_tdata),
        .seg_tid        (seg_tid),
        .seg_tuser      (seg_tuser),
        .seg_tlast      (seg_tlast),
        .seg_tvalid     (seg_tvalid),
        .seg_tready     (seg_tready),
        .drop_count     (drop_count),
        .trunc_count    (trunc_count),
        .proto_err_count(proto_err_count)
    );

    // Output monitor: every accepted FIFO entry must match the head of its queue.
    always @(negedge clk) begin
        ent_t got, want;
        if (!reset) begin
            for (int s = 0; s < NS; s++) begin
                if (seg_tvalid[s] && seg_tready[s]) begin
                    got = {seg_tdata[s*SW +: SW], seg_tid[s*MW +: MW], seg_tuser[s*3 +: 3],
                           seg_tlast[s]};
                    checks++;
                    assert (exp_q[s].size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_out seg%0d got %h expected nothing", s, got);
                    end
                    if (exp_q[s].size() != 0) begin
                        want = exp_q[s].pop_front();
                        checks++;
                        assert (got === want) else begin
                            errors++;
                            $error("FAIL out_seg%0d got %h expected %h", s, got, want);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [NS-1:0] ena, input logic [NS-1:0] sop,
                        input logic [NS-1:0] eop, input logic [NS-1:0] err,
                        input logic [NS*MW-1:0] mty, input logic [NS*SW-1:0] data);
        i_valid = 1'b1;
        i_ena   = ena;
        i_sop   = sop;
        i_eop   = eop;
        i_err   = err;
        i_mty   = mty;
        i_data  = data;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_ena   = '0;
        i_sop   = '0;
        i_eop   = '0;
        i_err   = '0;
    endtask

    task automatic push(input int s, input logic [SW-1:0] data, input logic [MW-1:0] tid,
                        input logic [2:0] user, input logic last);
        ent_t e;
        e = {data, tid, user, last};
        exp_q[s].push_back(e);
    endtask

    task automatic drain();
        int n;
        int pending;
        n = 0;
        seg_tready = '1;
        pending = 1;
        while (pending != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            pending = (seg_tvalid != '0) ? 1 : 0;
            for (int s = 0; s < NS; s++) pending += exp_q[s].size();
        end
        for (int s = 0; s < NS; s++) chk($sformatf("queue%0d_empty", s), exp_q[s].size(), 0);
        chk("drained_tvalid", 32'(seg_tvalid), 0);
    endtask

    initial begin
        logic [NS*MW-1:0] mty;
        logic [SW-1:0]    d;

        // Reset
        idle(3);
        reset = 1'b0;
        chk("reset_tvalid", 32'(seg_tvalid), 0);
        chk("reset_drop", drop_count, 0);
        chk("reset_trunc", trunc_count, 0);
        chk("reset_proto", proto_err_count, 0);

        // Single packet: sop seg0, eop seg2 with mty=5, seg3 disabled
        mty = '0;
        mty[2*MW +: MW] = 3'd5;
        push(0, 64'h1111_1111_1111_1111, 3'd0, 3'b110, 1'b0);
        push(1, 64'h2222_2222_2222_2222, 3'd0, 3'b100, 1'b0);
        push(2, 64'h0000_0000_00A5_A5A5, 3'd5, 3'b100, 1'b1);
        send(4'b0111, 4'b0001, 4'b0100, 4'b0000, mty,
             {64'h4444_4444_4444_4444, 64'hA5A5_A5A5_A5A5_A5A5,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        drain();
        chk("single_drop", drop_count, 0);
        chk("single_trunc", trunc_count, 0);
        chk("single_proto", proto_err_count, 0);

        // Admission drop: FIFO1 left with free=AF-1
        seg_tready = '0;
        for (int k = 0; k < DEPTH - AF; k++) begin
            d = 64'(k + 100);
            push(1, d, 3'd0, 3'b110, 1'b1);
            send(4'b0010, 4'b0010, 4'b0010, 4'b0000, '0, {64'h0, 64'h0, d, 64'h0});
        end
        send(4'b0111, 4'b0001, 4'b0100, 4'b0000, '0, {64'h0, 64'h33, 64'h22, 64'h11});
        idle(2);
        chk("admit_drop", drop_count, 1);
        chk("admit_proto", proto_err_count, 0);
        chk("admit_tvalid", 32'(seg_tvalid), 32'b0010);
        drain();
        push(0, 64'h51, 3'd0, 3'b110, 1'b0);
        push(1, 64'h52, 3'd0, 3'b100, 1'b0);
        push(2, 64'h53, 3'd0, 3'b100, 1'b1);
        send(4'b0111, 4'b0001, 4'b0100, 4'b0000, '0, {64'h0, 64'h53, 64'h52, 64'h51});
        drain();
        chk("admit_after_drop", drop_count, 1);

        // Truncation: long packet on seg0 with no draining
        seg_tready = '0;
        d = 64'hC000_0000_0000_0000;
        push(0, d, 3'd0, 3'b110, 1'b0);
        send(4'b0001, 4'b0001, 4'b0000, 4'b0000, '0, {192'h0, d});
        for (int k = 1; k <= DEPTH - 3; k++) begin
            d = 64'hC000_0000_0000_0000 | 64'(k);
            push(0, d, 3'd0, 3'b100, 1'b0);
            send(4'b0001, 4'b0000, 4'b0000, 4'b0000, '0, {192'h0, d});
        end
        d = 64'hC000_0000_0000_00EE;
        push(0, d, 3'd0, 3'b101, 1'b1);
        send(4'b0001, 4'b0000, 4'b0000, 4'b0000, '0, {192'h0, d});
        send(4'b0001, 4'b0000, 4'b0000, 4'b0000, '0, {192'h0, 64'hDEAD});
        send(4'b0001, 4'b0000, 4'b0001, 4'b0000, '0, {192'h0, 64'hBEEF});
        send(4'b0001, 4'b0001, 4'b0001, 4'b0000, '0, {192'h0, 64'hF00D});
        idle(2);
        chk("trunc_count", trunc_count, 1);
        chk("trunc_drop", drop_count, 2);
        chk("trunc_proto", proto_err_count, 0);
        drain();

        // Framing error: sop, sop, eop on seg0
        push(0, 64'h61, 3'd0, 3'b110, 1'b0);
        send(4'b0001, 4'b0001, 4'b0000, 4'b0000, '0, {192'h0, 64'h61});
        push(0, 64'h62, 3'd0, 3'b110, 1'b0);
        send(4'b0001, 4'b0001, 4'b0000, 4'b0000, '0, {192'h0, 64'h62});
        push(0, 64'h63, 3'd0, 3'b100, 1'b1);
        send(4'b0001, 4'b0000, 4'b0001, 4'b0000, '0, {192'h0, 64'h63});
        idle(2);
        chk("frame_proto", proto_err_count, 1);
        chk("frame_drop", drop_count, 2);
        drain();

        // Reset mid-packet: written entries are flushed, the orphan eop is a protocol error
        seg_tready = '0;
        send(4'b0111, 4'b0001, 4'b0000, 4'b0000, '0, {64'h0, 64'h73, 64'h72, 64'h71});
        idle(2);
        chk("midrst_written", 32'(seg_tvalid), 32'b0111);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("midrst_flushed", 32'(seg_tvalid), 0);
        chk("midrst_drop", drop_count, 0);
        chk("midrst_proto0", proto_err_count, 0);
        seg_tready = '1;
        send(4'b0001, 4'b0000, 4'b0001, 4'b0000, '0, {192'h0, 64'h74});
        idle(3);
        chk("midrst_proto", proto_err_count, 1);
        chk("midrst_tvalid", 32'(seg_tvalid), 0);

        // Saturation: three drops in one cycle on top of 2^32-2
        seg_tready = '0;
        for (int k = 0; k < DEPTH - AF; k++) begin
            d = 64'(k + 200);
            push(3, d, 3'd0, 3'b110, 1'b1);
            send(4'b1000, 4'b1000, 4'b1000, 4'b0000, '0, {d, 192'h0});
        end
        idle(2);
        force dut.drop_cnt_q = 32'hFFFF_FFFE;
        idle(1);
        release dut.drop_cnt_q;
        idle(1);
        chk("sat_preload", drop_count, 32'hFFFF_FFFE);
        send(4'b0111, 4'b0111, 4'b0111, 4'b0000, '0, {64'h0, 64'h83, 64'h82, 64'h81});
        idle(2);
        chk("sat_drop", drop_count, 32'hFFFF_FFFF);
        send(4'b0001, 4'b0001, 4'b0001, 4'b0000, '0, {192'h0, 64'h84});
        idle(2);
        chk("sat_hold", drop_count, 32'hFFFF_FFFF);
        chk("sat_proto", proto_err_count, 1);
        chk("sat_trunc", trunc_count, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
